// File: rtl/aurora_qpll_seq_pkg.sv
`default_nettype none
// aurora_qpll_seq_pkg: shared types and sizing helpers for the QPLL reset sequencer. Rev 1.0

package aurora_qpll_seq_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_READY     = 3'd3,
    ST_FAULT     = 3'd4
  } qpll_state_t;

  localparam int RETRY_W = 8;

  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aurora_sync_2ff.sv
`default_nettype none
// aurora_sync_2ff: single-bit two-flop synchronizer with a configurable reset value. Rev 1.0

module aurora_sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/aurora_qpll_reset_seq.sv
`default_nettype none
// aurora_qpll_reset_seq: QPLL reset/lock supervisor with bounded retries and sticky fault. Rev 1.0
// Optional lock-loss counter port enabled by defining AURORA_QPLL_SEQ_LOSS_CNT_EN.

module aurora_qpll_reset_seq
  import aurora_qpll_seq_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7
) (
  input  logic               init_clk_in,
  input  logic               reset_in,
  input  logic               qplllock_in,
  input  logic               qpllrefclklost_in,
  input  logic               restart_in,
  output logic               qpll_reset_out,
  output logic               qpll_ready_out,
  output logic               fault_out,
  output logic [RETRY_W-1:0] retry_count_out
`ifdef AURORA_QPLL_SEQ_LOSS_CNT_EN
  ,
  output logic [15:0]        lock_loss_count_out
`endif
);

  localparam int TW = timer_width(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [TW-1:0]      RESET_LAST  = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0]      LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0]      STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  logic lock_s, lost_s;

  aurora_sync_2ff #(.RST_VAL(1'b0)) u_sync_lock (
    .clk (init_clk_in),
    .rst (reset_in),
    .d   (qplllock_in),
    .q   (lock_s)
  );

  aurora_sync_2ff #(.RST_VAL(1'b0)) u_sync_lost (
    .clk (init_clk_in),
    .rst (reset_in),
    .d   (qpllrefclklost_in),
    .q   (lost_s)
  );

  qpll_state_t        state, state_nx;
  logic [TW-1:0]      timer, timer_nx;
  logic [RETRY_W-1:0] retry, retry_nx;
  logic               fail;

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    retry_nx = retry;
    fail     = 1'b0;
    case (state)
      ST_ASSERT: begin
        if (lost_s) begin
          timer_nx = '0;
        end else if (timer == RESET_LAST) begin
          timer_nx = '0;
          state_nx = ST_WAIT_LOCK;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          timer_nx = '0;
          state_nx = ST_STABLE;
        end else if (timer == LOCK_LAST) begin
          fail = 1'b1;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      ST_STABLE: begin
        if (!lock_s || lost_s) begin
          fail = 1'b1;
        end else if (timer == STABLE_LAST) begin
          timer_nx = '0;
          state_nx = ST_READY;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      ST_READY: begin
        if (!lock_s || lost_s) begin
          retry_nx = '0;
          timer_nx = '0;
          state_nx = ST_ASSERT;
        end
      end
      ST_FAULT: ;
      default: state_nx = ST_ASSERT;
    endcase

    // A lock drop and refclk loss in the same cycle arrive here as one fail.
    if (fail) begin
      timer_nx = '0;
      if (retry == RETRY_MAX) begin
        state_nx = ST_FAULT;
      end else begin
        retry_nx = retry + 1'b1;
        state_nx = ST_ASSERT;
      end
    end

    if (restart_in) begin
      state_nx = ST_ASSERT;
      timer_nx = '0;
      retry_nx = '0;
    end
  end

  // Outputs are decoded from the next state so they move with the state register.
  always_ff @(posedge init_clk_in) begin
    if (reset_in) begin
      state           <= ST_ASSERT;
      timer           <= '0;
      retry           <= '0;
      qpll_reset_out  <= 1'b1;
      qpll_ready_out  <= 1'b0;
      fault_out       <= 1'b0;
      retry_count_out <= '0;
    end else begin
      state           <= state_nx;
      timer           <= timer_nx;
      retry           <= retry_nx;
      qpll_reset_out  <= (state_nx == ST_ASSERT) || (state_nx == ST_FAULT);
      qpll_ready_out  <= (state_nx == ST_READY);
      fault_out       <= (state_nx == ST_FAULT);
      retry_count_out <= retry_nx;
    end
  end

`ifdef AURORA_QPLL_SEQ_LOSS_CNT_EN
  logic        loss_evt;
  logic [15:0] loss_cnt;

  assign loss_evt = (state == ST_READY) && !restart_in && (!lock_s || lost_s);

  always_ff @(posedge init_clk_in) begin
    if (reset_in) begin
      loss_cnt <= '0;
    end else if (loss_evt && (loss_cnt != 16'hFFFF)) begin
      loss_cnt <= loss_cnt + 1'b1;
    end
  end

  assign lock_loss_count_out = loss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aurora_qpll_reset_seq.sv
`default_nettype none
// tb_aurora_qpll_reset_seq: directed plus random stimulus, per-cycle scoreboard against a countdown model. Rev 1.0

module tb_aurora_qpll_reset_seq;

  localparam int RC = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int MR = 2;

  localparam int P_RESET  = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_READY  = 3;
  localparam int P_FAULT  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lock = 1'b0;
  logic        lost = 1'b0;
  logic        restart = 1'b0;
  logic        rst_o, rdy, flt;
  logic [7:0]  rcnt;
  logic [15:0] lcnt;

  always #5 clk = ~clk;

  aurora_qpll_reset_seq #(
    .RESET_CYCLES  (RC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .MAX_RETRIES   (MR)
  ) dut (
    .init_clk_in       (clk),
    .reset_in          (rst),
    .qplllock_in       (lock),
    .qpllrefclklost_in (lost),
    .restart_in        (restart),
    .qpll_reset_out    (rst_o),
    .qpll_ready_out    (rdy),
    .fault_out         (flt),
    .retry_count_out   (rcnt)
`ifdef AURORA_QPLL_SEQ_LOSS_CNT_EN
    ,
    .lock_loss_count_out (lcnt)
`endif
  );

`ifndef AURORA_QPLL_SEQ_LOSS_CNT_EN
  assign lcnt = '0;
`endif

  typedef struct packed {
    logic        rst_o;
    logic        rdy;
    logic        flt;
    logic [7:0]  rcnt;
    logic [15:0] lcnt;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: phase plus cycles-remaining countdown, synchronizer as a 2-deep pipe.
  int   m_phase, m_left, m_tries, m_losses;
  bit [1:0] m_lk, m_ls;

  function automatic void start_attempt();
    m_phase = P_RESET;
    m_left  = RC;
  endfunction

  function automatic void attempt_failed();
    if (m_tries == MR) m_phase = P_FAULT;
    else begin
      m_tries++;
      start_attempt();
    end
  endfunction

  function automatic void model_step();
    bit lk, ls;
    lk = m_lk[1];
    ls = m_ls[1];
    if (rst) begin
      start_attempt();
      m_tries  = 0;
      m_losses = 0;
      m_lk     = '0;
      m_ls     = '0;
      return;
    end
    if (restart) begin
      m_tries = 0;
      start_attempt();
    end else begin
      case (m_phase)
        P_RESET: begin
          if (ls) m_left = RC;
          else begin
            m_left--;
            if (m_left == 0) begin m_phase = P_WAIT; m_left = LT; end
          end
        end
        P_WAIT: begin
          if (lk) begin m_phase = P_STABLE; m_left = SC; end
          else begin
            m_left--;
            if (m_left == 0) attempt_failed();
          end
        end
        P_STABLE: begin
          if (!lk || ls) attempt_failed();
          else begin
            m_left--;
            if (m_left == 0) m_phase = P_READY;
          end
        end
        P_READY: begin
          if (!lk || ls) begin
            if (m_losses < 65535) m_losses++;
            m_tries = 0;
            start_attempt();
          end
        end
        default: ;
      endcase
    end
    m_lk = {m_lk[0], lock};
    m_ls = {m_ls[0], lost};
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.rst_o = (m_phase == P_RESET) || (m_phase == P_FAULT);
    o.rdy   = (m_phase == P_READY);
    o.flt   = (m_phase == P_FAULT);
    o.rcnt  = 8'(m_tries);
`ifdef AURORA_QPLL_SEQ_LOSS_CNT_EN
    o.lcnt  = 16'(m_losses);
`else
    o.lcnt  = 16'd0;
`endif
    return o;
  endfunction

  always @(posedge clk) begin
    model_step();
    exp_q.push_back(model_obs());
  end

  obs_t e_obs, a_obs;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_obs = exp_q.pop_front();
      a_obs = {rst_o, rdy, flt, rcnt, lcnt};
      vectors++;
      if (a_obs !== e_obs) begin
        miscompares++;
        $display("FAIL outputs t=%0t got rst=%b rdy=%b flt=%b retry=%0d loss=%0d want rst=%b rdy=%b flt=%b retry=%0d loss=%0d",
                 $time, a_obs.rst_o, a_obs.rdy, a_obs.flt, a_obs.rcnt, a_obs.lcnt,
                 e_obs.rst_o, e_obs.rdy, e_obs.flt, e_obs.rcnt, e_obs.lcnt);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic cur(input int which);
    case (which)
      0:       return rst_o;
      1:       return rdy;
      default: return flt;
    endcase
  endfunction

  task automatic wait_sig(input int which, input logic val, input int max, input string name);
    int k;
    k = 0;
    while (cur(which) !== val && k < max) begin
      tick(1);
      k++;
    end
    vectors++;
    if (cur(which) !== val) begin
      miscompares++;
      $display("FAIL timeout %s got %b want %b within %0d cycles", name, cur(which), val, max);
    end
  endtask

  initial begin
    tick(3);
    rst = 1'b0;

    // Clean lock after reset release
    wait_sig(0, 1'b0, 20, "reset_release");
    tick(2);
    lock = 1'b1;
    wait_sig(1, 1'b1, 40, "first_ready");
    tick(5);

    // One-cycle lock drop while ready
    lock = 1'b0;
    tick(1);
    lock = 1'b1;
    wait_sig(1, 1'b0, 10, "ready_drop");
    wait_sig(1, 1'b1, 60, "ready_return");
    tick(3);

    // Lock never comes: retries exhaust into fault
    lock = 1'b0;
    wait_sig(2, 1'b1, 120, "fault_entry");
    tick(100);

    // Restart from fault
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    wait_sig(0, 1'b0, 20, "restart_release");
    tick($urandom_range(0, 6));
    lock = 1'b1;
    wait_sig(1, 1'b1, 40, "restart_ready");

    // Lock glitch in the middle of the stability window
    lock = 1'b0;
    tick(4);
    wait_sig(0, 1'b0, 20, "glitch_release");
    tick(1);
    lock = 1'b1;
    tick(7);
    lock = 1'b0;
    tick(1);
    lock = 1'b1;
    wait_sig(1, 1'b1, 80, "ready_after_glitch");

    // Refclk lost held during reset, then reset_in mid-wait
    lock = 1'b0;
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    lost = 1'b1;
    tick(30);
    lost = 1'b0;
    wait_sig(0, 1'b0, 20, "lost_release");
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);

    // Random soak
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) lock = ~lock;
      lost    = ($urandom_range(0, 299) == 0);
      restart = ($urandom_range(0, 499) == 0);
      rst     = ($urandom_range(0, 999) == 0);
      tick(1);
    end
    lost = 1'b0;
    restart = 1'b0;
    rst = 1'b0;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
